// File: rtl/bus_initiator_8088_if.sv
// Request/response handshake plus 8088 minimum-mode bus pins (except the tristate AD bus).
// master: the bus initiator; slave: the request source / bus responder side.
interface bus_initiator_8088_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_iom;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [11:0] A;
    logic        ALE;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic        DTR;
    logic        DEN;
    logic        READY;

    modport master (
        input  req_valid, req_write, req_iom, req_addr, req_wdata, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output A, ALE, IOM, RD, WR, DTR, DEN
    );

    modport slave (
        output req_valid, req_write, req_iom, req_addr, req_wdata, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  A, ALE, IOM, RD, WR, DTR, DEN
    );
endinterface

// File: rtl/bus_initiator_8088.sv
// 8088 minimum-mode bus master: request/response handshake in, T1-T4/Tw multiplexed AD-bus cycles out.
// Optional feature macro BUS_TIMEOUT_EN: abort a cycle with rsp_err after WAIT_MAX wait states.
module bus_initiator_8088 #(
    parameter int WAIT_MAX = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    bus_initiator_8088_if.master bus,
    // AD stays a plain port so the tristate resolves at the pin, not inside the interface.
    inout  wire  [7:0]           AD
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
        $error("bus_initiator_8088: WAIT_MAX must be in 1..255");
    end

    logic [2:0]  state;
    logic        wr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  ad_q;
    logic        ad_oe;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic [11:0] a_q;
    logic        ale_q;
    logic        iom_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic        dtr_q;
    logic        den_n_q;
    logic        accept;
    logic        waiting;
    logic        timeout;

    assign accept  = bus.req_valid && req_ready_q;
    assign waiting = (state == S_T3) || (state == S_TW);

`ifdef BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       rsp_err_q;

    // wait_cnt equals the number of TW cycles entered so far in this bus cycle.
    assign timeout = (state == S_TW) && (wait_cnt == WAIT_MAX[7:0]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == S_T2)
                wait_cnt <= '0;
            else if (waiting && !bus.READY && !timeout)
                wait_cnt <= wait_cnt + 8'd1;
            if (waiting && (bus.READY || timeout))
                rsp_err_q <= !bus.READY;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // NOTE: every pin is a flop updated with non-blocking assignments, so all outputs
    // change together just after the edge and the next-state decision sees old values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            ad_q        <= '0;
            ad_oe       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            a_q         <= '0;
            ale_q       <= 1'b0;
            iom_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            dtr_q       <= 1'b1;
            den_n_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_T4: begin
                    rsp_valid_q <= 1'b0;
                    if (accept) begin
                        state       <= S_T1;
                        wr_q        <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        ad_q        <= bus.req_addr[7:0];
                        ad_oe       <= 1'b1;
                        a_q         <= bus.req_iom ? {4'h0, bus.req_addr[15:8]} : bus.req_addr[19:8];
                        iom_q       <= bus.req_iom;
                        dtr_q       <= bus.req_write;
                        ale_q       <= 1'b1;
                        req_ready_q <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        dtr_q <= 1'b1;
                    end
                end
                S_T1: begin
                    state   <= S_T2;
                    ale_q   <= 1'b0;
                    den_n_q <= 1'b0;
                    if (wr_q) begin
                        wr_n_q <= 1'b0;
                        ad_q   <= wdata_q;
                    end else begin
                        rd_n_q <= 1'b0;
                        ad_oe  <= 1'b0;
                    end
                end
                S_T2: state <= S_T3;
                S_T3, S_TW: begin
                    if (bus.READY || timeout) begin
                        state       <= S_T4;
                        rd_n_q      <= 1'b1;
                        wr_n_q      <= 1'b1;
                        den_n_q     <= 1'b1;
                        ad_oe       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        // Only the READY=1 edge captures read data; a timeout returns all ones.
                        if (!bus.READY)
                            rsp_rdata_q <= 8'hFF;
                        else if (!wr_q)
                            rsp_rdata_q <= AD;
                    end else begin
                        state <= S_TW;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign AD            = ad_oe ? ad_q : 8'hzz;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.A         = a_q;
    assign bus.ALE       = ale_q;
    assign bus.IOM       = iom_q;
    assign bus.RD        = rd_n_q;
    assign bus.WR        = wr_n_q;
    assign bus.DTR       = dtr_q;
    assign bus.DEN       = den_n_q;
endmodule

// File: tb/tb_bus_initiator_8088.sv
// Self-checking bench for bus_initiator_8088: directed and random bus cycles against a
// transaction-timeline model; honours BUS_TIMEOUT_EN when defined.
module tb_bus_initiator_8088;
    localparam int WAIT_MAX = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    wire  [7:0] AD;
    logic [7:0] tb_ad;
    logic       tb_ad_en;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ale_prev = 0;
    int          ale_cur  = 0;
    logic [11:0] last_a;
    logic        last_iom;

    assign AD = tb_ad_en ? tb_ad : 8'hzz;

    bus_initiator_8088_if bus ();

    bus_initiator_8088 #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus),
        .AD      (AD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ale", bus.ALE, 1'b0);
        check("rst_rd", bus.RD, 1'b1);
        check("rst_wr", bus.WR, 1'b1);
        check("rst_den", bus.DEN, 1'b1);
        check("rst_dtr", bus.DTR, 1'b1);
        check("rst_a", bus.A, 12'h000);
        check("rst_iom", bus.IOM, 1'b0);
        check("rst_ad_released", AD, tb_ad);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
    endtask

    // Called about 2 time units into a clock interval; asserts reset asynchronously.
    task automatic reset_now();
        #1;
        RESET_N  = 1'b0;
        tb_ad_en = 1'b1;
        tb_ad    = 8'h5A;
        #1;
        check_reset_values();
        repeat (3) begin
            @(posedge CLK);
            #2;
            check("rst_hold_rsp_valid", bus.rsp_valid, 1'b0);
            check("rst_hold_ale", bus.ALE, 1'b0);
        end
        RESET_N  = 1'b1;
        last_a   = '0;
        last_iom = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
        tb_ad_en  = 1'b1;
        tb_ad     = 8'($urandom);
        bus.READY = 1'($urandom);
        #1;
        check("idle_ale", bus.ALE, 1'b0);
        check("idle_rd", bus.RD, 1'b1);
        check("idle_wr", bus.WR, 1'b1);
        check("idle_den", bus.DEN, 1'b1);
        check("idle_dtr", bus.DTR, 1'b1);
        check("idle_req_ready", bus.req_ready, 1'b1);
        check("idle_rsp_valid", bus.rsp_valid, 1'b0);
        check("idle_ad_released", AD, tb_ad);
        check("idle_a_hold", bus.A, last_a);
        check("idle_iom_hold", bus.IOM, last_iom);
    endtask

    // One bus cycle as a timeline: interval 0 is T1, 1 is T2, 2..2+n are T3/TW, 3+n is T4,
    // where n is the number of READY=0 samples (capped at WAIT_MAX when the timeout exists).
    // Must be called while the DUT is in IDLE or T4; returns during the T4 interval.
    task automatic do_txn(input bit wr, input bit iom, input logic [19:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata,
                          input int nwait, input int abort_at);
        bit          err;
        int          n_eff;
        int          last;
        logic [11:0] exp_a;
        logic [7:0]  exp_rd;
        err    = TO_EN && (nwait > WAIT_MAX);
        n_eff  = err ? WAIT_MAX : nwait;
        last   = 3 + n_eff;
        exp_a  = iom ? {4'h0, addr[15:8]} : addr[19:8];
        exp_rd = err ? 8'hFF : rdata;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_iom   = iom;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int c = 0; c <= last; c++) begin
            @(posedge CLK);
            #1;
            if (c == 0) begin
                bus.req_valid = 1'b0;
                bus.req_write = 1'($urandom);
                bus.req_iom   = 1'($urandom);
                bus.req_addr  = 20'($urandom);
                bus.req_wdata = 8'($urandom);
                tb_ad_en      = 1'b0;
            end else if (wr && c < last) begin
                tb_ad_en = 1'b0;
            end else begin
                tb_ad_en = 1'b1;
                tb_ad    = (!wr && c == 2 + nwait) ? rdata : 8'($urandom);
            end
            if (c >= 2 && c < 2 + nwait)
                bus.READY = 1'b0;
            else if (c == 2 + nwait)
                bus.READY = 1'b1;
            else
                bus.READY = 1'($urandom);
            #1;
            if (c == 0) begin
                ale_prev = ale_cur;
                ale_cur  = cyc;
                check("t1_ale", bus.ALE, 1'b1);
                check("t1_ad_addr", AD, addr[7:0]);
                check("t1_a", bus.A, exp_a);
                check("t1_iom", bus.IOM, iom);
                check("t1_dtr", bus.DTR, wr);
                check("t1_den", bus.DEN, 1'b1);
                check("t1_rd", bus.RD, 1'b1);
                check("t1_wr", bus.WR, 1'b1);
                check("t1_req_ready", bus.req_ready, 1'b0);
                check("t1_rsp_valid", bus.rsp_valid, 1'b0);
            end else if (c < last) begin
                check("data_ale", bus.ALE, 1'b0);
                check("data_den", bus.DEN, 1'b0);
                check("data_rd", bus.RD, wr);
                check("data_wr", bus.WR, !wr);
                check("data_ad", AD, wr ? wdata : tb_ad);
                check("data_a", bus.A, exp_a);
                check("data_iom", bus.IOM, iom);
                check("data_dtr", bus.DTR, wr);
                check("data_req_ready", bus.req_ready, 1'b0);
                check("data_rsp_valid", bus.rsp_valid, 1'b0);
            end else begin
                check("t4_ale", bus.ALE, 1'b0);
                check("t4_rd", bus.RD, 1'b1);
                check("t4_wr", bus.WR, 1'b1);
                check("t4_den", bus.DEN, 1'b1);
                check("t4_ad_released", AD, tb_ad);
                check("t4_a_hold", bus.A, exp_a);
                check("t4_iom_hold", bus.IOM, iom);
                check("t4_rsp_valid", bus.rsp_valid, 1'b1);
                check("t4_req_ready", bus.req_ready, 1'b1);
                check("t4_rsp_err", bus.rsp_err, err);
                if (!wr || err)
                    check("t4_rsp_rdata", bus.rsp_rdata, exp_rd);
            end
            if (c == abort_at) begin
                reset_now();
                return;
            end
        end
        last_a   = exp_a;
        last_iom = iom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N       = 1'b1;
        tb_ad_en      = 1'b1;
        tb_ad         = 8'hC3;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_iom   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.READY     = 1'b1;
        last_a        = '0;
        last_iom      = 1'b0;
        #1 RESET_N = 1'b0;
        #2;
        check_reset_values();
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        idle_cycle();
        idle_cycle();

        // Directed cycles from the bring-up plan.
        do_txn(1'b1, 1'b0, 20'h12345, 8'hA5, 8'h00, 0, -1);
        idle_cycle();
        do_txn(1'b0, 1'b0, 20'h8FFFF, 8'h00, 8'h3C, 0, -1);
        idle_cycle();
        do_txn(1'b0, 1'b1, 20'hAFF04, 8'h00, 8'h9E, 2, -1);
        idle_cycle();

        // Back-to-back writes with req_valid held, then the same with one IDLE gap.
        do_txn(1'b1, 1'b0, 20'h00010, 8'h11, 8'h00, 0, -1);
        do_txn(1'b1, 1'b0, 20'h00011, 8'h22, 8'h00, 0, -1);
        check("ale_spacing_b2b", ale_cur - ale_prev, 4);
        idle_cycle();
        do_txn(1'b1, 1'b0, 20'h00012, 8'h33, 8'h00, 0, -1);
        idle_cycle();
        do_txn(1'b0, 1'b0, 20'h00013, 8'h00, 8'h44, 0, -1);
        check("ale_spacing_gap", ale_cur - ale_prev, 5);
        idle_cycle();

        // READY held low far longer than WAIT_MAX.
        do_txn(1'b0, 1'b0, 20'h54321, 8'h00, 8'h77, 12, -1);
        idle_cycle();

        // Reset in T3 of a read, then in T2 of a write; each followed by a normal cycle.
        do_txn(1'b0, 1'b0, 20'h0ABCD, 8'h00, 8'hE1, 1, 2);
        idle_cycle();
        do_txn(1'b0, 1'b0, 20'h0ABCE, 8'h00, 8'hD2, 0, -1);
        idle_cycle();
        do_txn(1'b1, 1'b1, 20'h0BEEF, 8'h96, 8'h00, 0, 1);
        idle_cycle();
        do_txn(1'b1, 1'b0, 20'hFEDCB, 8'h69, 8'h00, 1, -1);

        // Random traffic: random direction, space, address, data, wait states and gaps.
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
            do_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 6)), -1);
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_initiator_8088.md
# bus_initiator_8088

Synthesizable 8088-style minimum-mode bus master that turns a simple request/response interface into multiplexed AD-bus cycles (T1–T4 with wait states). It drives the same ALE/IOM/RD/WR/DTR/DEN/AD/A pins the memory and I/O responder FSMs consume behind the 8282 latch and 8286 transceiver. It is the initiator end of that protocol and replaces the behavioural CPU model when directed bus traffic is needed, for example DMA-style or bench-driven cycles.

## Interface
Parameters:
- WAIT_MAX, 8, maximum wait states (Tw) before a cycle is aborted; used only with BUS_TIMEOUT_EN; legal range 1–255.

Ports:
- CLK  in  1  bus clock; all state changes on the rising edge.
- RESET_N  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = write cycle, 0 = read cycle.
- req_iom  in  1  1 = I/O cycle, 0 = memory cycle.
- req_addr  in  20  byte address; only [15:0] is used for I/O.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid on reads.
- rsp_err  out  1  cycle aborted by timeout; valid with rsp_valid.
- AD  inout  8  multiplexed address/data bus; tristated when not driven.
- A  out  12  address bits [19:8].
- ALE  out  1  address latch enable, active-high.
- IOM  out  1  1 = I/O, 0 = memory.
- RD, WR  out  1  strobes, active-low.
- DTR  out  1  1 = transmit (write), 0 = receive (read).
- DEN  out  1  transceiver enable, active-low.
- READY  in  1  responder ready; low inserts Tw.

## Operation
States are IDLE, T1, T2, T3, TW, T4. All pin outputs are registered.
- IDLE: req_ready=1, ALE=0, RD=WR=DEN=DTR=1, AD=z. A and IOM hold their last values.
- Accept (IDLE or T4, req_valid=1): next state is T1. The block latches write, iom, addr and wdata.
- T1: ALE=1, AD=addr[7:0], DEN=1.
  - A=addr[19:8] for memory cycles.
  - A={4'h0, addr[15:8]} for I/O cycles.
  - IOM=iom; DTR=write.
- T2: ALE=0, DEN=0. A, IOM and DTR hold.
  - Write: WR=0, AD=wdata.
  - Read: RD=0, AD=z.
- T3 and TW: the T2 pin values hold. On the closing edge of T3 or TW:
  - READY=1: next state is T4. On reads, rsp_rdata<=AD.
  - READY=0: next state is TW.
- T4: RD=WR=DEN=1, AD=z, ALE=0, rsp_valid=1, req_ready=1. Next state is T1 if a request is accepted, otherwise IDLE.
- rsp_err=0 on every normal completion.
- I/O addresses never drive A[19:16] non-zero.
- Requests are ignored outside IDLE and T4; req_addr and req_wdata changes mid-cycle have no effect.

## Timing
- Reset values: req_ready=1 after RESET_N deassert, rsp_valid=0, rsp_rdata=0, rsp_err=0, ALE=0, IOM=0, A=0, RD=WR=DEN=DTR=1, AD=z, state IDLE.
- Accept at edge k:
  - T1 outputs are visible after edge k.
  - T2 outputs are visible after k+1.
  - T3 outputs are visible after k+2.
  - READY is sampled at k+3; rsp_valid is high for the cycle after k+3.
  - Zero-wait latency is 3 cycles. Each low READY sample adds exactly one cycle.
- Back-to-back requests with req_valid held: ALE pulses every 4 cycles, because T4 overlaps the next accept.
- Single requests with an IDLE gap: 5 cycles minimum between ALE pulses.
- Read data is captured only on the edge that sees READY=1. Data sampled during TW is discarded.
- Asynchronous reset during any state immediately forces the reset values above, including AD=z. No rsp_valid is produced for the interrupted cycle.
- READY is ignored in T1, T2 and T4.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A wait counter is cleared in T2 and counts TW cycles.
  - When the counter reaches WAIT_MAX and READY=0 is sampled, the next state is T4 with rsp_err=1 and rsp_rdata=8'hFF.
- BUS_TIMEOUT_EN undefined:
  - No counter is built; TW persists until READY=1.
  - rsp_err is tied to 0.

## Test plan
- Memory write, addr 20'h12345, data 8'hA5, READY=1:
  - T1: ALE=1, AD=8'h45, A=12'h123, IOM=0, DTR=1.
  - T2–T3: WR=0, DEN=0, AD=8'hA5.
  - rsp_valid 3 cycles after accept, rsp_err=0.
- Memory read, addr 20'h8FFFF, responder drives 8'h3C, READY=1:
  - RD=0 and DTR=0 in T2–T3, AD tristated by the master.
  - rsp_rdata=8'h3C.
- I/O read, addr 16'hFF04, READY low for 2 samples:
  - IOM=1, A=12'h0FF.
  - Two TW cycles, rsp_valid 5 cycles after accept with correct data.
- Two back-to-back writes to 20'h00010 and 20'h00011, req_valid held:
  - Second ALE exactly 4 cycles after the first.
  - Two rsp_valid pulses.
- BUS_TIMEOUT_EN defined, WAIT_MAX=4, READY stuck 0:
  - Exactly 4 TW, then T4 with rsp_err=1, rsp_rdata=8'hFF.
  - With the macro undefined, the master stays in TW until READY rises, then completes with rsp_err=0.
- RESET_N asserted in T3 of a read:
  - RD=1, DEN=1, AD=z immediately; no rsp_valid.
  - After release, a new request completes normally.
